// File: rtl/aska_mnpg_pkg.sv
// Shared constants for the multi-channel pulse generator: config word fields,
// sequencer state encoding and the channel-index width helper.
package aska_mnpg_pkg;

  localparam int unsigned C0_PER_LSB  = 0;
  localparam int unsigned C0_PER_MSB  = 11;
  localparam int unsigned C0_AMP_LSB  = 12;
  localparam int unsigned C0_AMP_MSB  = 17;
  localparam int unsigned C0_ON_LSB   = 24;
  localparam int unsigned C0_ON_MSB   = 31;

  localparam int unsigned C1_OFF_LSB  = 0;
  localparam int unsigned C1_OFF_MSB  = 9;
  localparam int unsigned C1_PD_LSB   = 10;
  localparam int unsigned C1_PD_MSB   = 12;
  localparam int unsigned C1_EN_BIT   = 13;
  localparam int unsigned C1_AN_LSB   = 14;
  localparam int unsigned C1_AN_MSB   = 18;
  localparam int unsigned C1_CA_LSB   = 19;
  localparam int unsigned C1_CA_MSB   = 23;
  localparam int unsigned C1_RMP_LSB  = 24;
  localparam int unsigned C1_RMP_MSB  = 29;

  localparam int unsigned EW  = 5;
  localparam int unsigned PDW = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PH1,
    S_GAP,
    S_PH2,
    S_DEAD
  } seq_state_e;

  // Channel index width; a single channel still gets a 1-bit index.
  function automatic int unsigned chw(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/aska_mnpg_chan.sv
// One stimulation channel: config registers, period/ON/OFF/ramp counters,
// and the pending request plus sticky overrun flag seen by the arbiter.
module aska_mnpg_chan
  import aska_mnpg_pkg::*;
#(
  parameter int unsigned NELE = 32,
  parameter int unsigned AW   = 6
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            we,
  input  logic            word,
  input  logic [31:0]     wdata,
  input  logic            grant,
  output logic            pending,
  output logic            overrun,
  output logic [EW-1:0]   anode,
  output logic [EW-1:0]   cathode,
  output logic [AW-1:0]   level,
  output logic [PDW-1:0]  pd
);

  logic [31:0] conf0, conf1, conf0_n, conf1_n;
  logic [11:0] cnt;
  logic [7:0]  idx;
  logic        in_off;
  logic [9:0]  off_cnt;
  logic        valid_c, valid_n, bnd, on_bnd;
  logic [11:0] period_n;
  logic [7:0]  on_n;
  logic [9:0]  off_n;
  logic [5:0]  amp, ramp, lvl6;
  logic [13:0] ramp_lvl;
  logic        unused_bits;

  function automatic logic is_valid(input logic en, input logic [11:0] per,
                                    input logic [EW-1:0] a, input logic [EW-1:0] c);
    return en && (per != '0) && (a != c) && (32'(a) < NELE) && (32'(c) < NELE);
  endfunction

  always_comb begin
    conf0_n = conf0;
    conf1_n = conf1;
    if (we) begin
      if (word) conf1_n = wdata;
      else      conf0_n = wdata;
    end
  end

  // Validity is judged on post-write contents so a write that enables the
  // channel raises pending on the very edge that stores it.
  assign valid_c  = is_valid(conf1[C1_EN_BIT], conf0[C0_PER_MSB:C0_PER_LSB],
                             conf1[C1_AN_MSB:C1_AN_LSB], conf1[C1_CA_MSB:C1_CA_LSB]);
  assign valid_n  = is_valid(conf1_n[C1_EN_BIT], conf0_n[C0_PER_MSB:C0_PER_LSB],
                             conf1_n[C1_AN_MSB:C1_AN_LSB], conf1_n[C1_CA_MSB:C1_CA_LSB]);
  assign period_n = conf0_n[C0_PER_MSB:C0_PER_LSB];
  assign on_n     = conf0_n[C0_ON_MSB:C0_ON_LSB];
  assign off_n    = conf1_n[C1_OFF_MSB:C1_OFF_LSB];
  assign bnd      = (cnt == 12'd1);
  assign on_bnd   = bnd && !in_off;

  assign amp      = conf0[C0_AMP_MSB:C0_AMP_LSB];
  assign ramp     = conf1[C1_RMP_MSB:C1_RMP_LSB];
  assign ramp_lvl = (14'(idx) + 14'd1) * 14'(ramp);
  assign lvl6     = ((ramp == '0) || (ramp_lvl >= 14'(amp))) ? amp : ramp_lvl[5:0];
  assign level    = AW'(lvl6);
  assign pd       = (conf1[C1_PD_MSB:C1_PD_LSB] == '0) ? PDW'(1) : conf1[C1_PD_MSB:C1_PD_LSB];
  assign anode    = conf1[C1_AN_MSB:C1_AN_LSB];
  assign cathode  = conf1[C1_CA_MSB:C1_CA_LSB];

  // Reserved and next-state-only fields of the stored words.
  assign unused_bits = ^{conf0, conf1};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      conf0   <= '0;
      conf1   <= '0;
      cnt     <= '0;
      idx     <= '0;
      in_off  <= 1'b0;
      off_cnt <= '0;
      pending <= 1'b0;
      overrun <= 1'b0;
    end else begin
      conf0 <= conf0_n;
      conf1 <= conf1_n;
      if (!valid_n) begin
        cnt     <= '0;
        idx     <= '0;
        in_off  <= 1'b0;
        off_cnt <= '0;
        pending <= 1'b0;
      end else if (!valid_c) begin
        cnt     <= period_n;
        idx     <= '0;
        in_off  <= 1'b0;
        off_cnt <= '0;
        pending <= 1'b1;
      end else begin
        cnt     <= bnd ? period_n : cnt - 12'd1;
        pending <= (pending && !grant) || on_bnd;
        if (on_bnd && pending && !grant) overrun <= 1'b1;
        if (grant) begin
          if ((on_n != '0) && (off_n != '0) && ({1'b0, idx} + 9'd1 >= {1'b0, on_n})) begin
            in_off  <= 1'b1;
            idx     <= '0;
            off_cnt <= '0;
          end else if (idx != '1) begin
            idx <= idx + 8'd1;
          end
        end else if (bnd && in_off) begin
          if ({1'b0, off_cnt} + 11'd1 >= {1'b0, off_n}) begin
            in_off  <= 1'b0;
            off_cnt <= '0;
          end else begin
            off_cnt <= off_cnt + 10'd1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/aska_mnpg.sv
// Multi-channel biphasic pulse generator: NCH channel timers share one H-bridge
// and DAC through a fixed-priority arbiter and a registered pulse sequencer.
module aska_mnpg
  import aska_mnpg_pkg::*;
#(
  parameter int unsigned NCH  = 4,
  parameter int unsigned NELE = 32,
  parameter int unsigned AW   = 6,
  localparam int unsigned CHW = chw(NCH)
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            cfg_we,
  input  logic [CHW:0]    cfg_addr,
  input  logic [31:0]     cfg_wdata,
  output logic [NELE-1:0] up_switches,
  output logic [NELE-1:0] down_switches,
  output logic [AW-1:0]   DAC,
  output logic            pulse_active,
  output logic [CHW-1:0]  active_ch,
  output logic [NCH-1:0]  overrun
);

  logic [NCH-1:0]           pend, gnt;
  logic [NCH-1:0][EW-1:0]   an, ca;
  logic [NCH-1:0][AW-1:0]   lvl;
  logic [NCH-1:0][PDW-1:0]  pdv;

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    aska_mnpg_chan #(.NELE(NELE), .AW(AW)) u_chan (
      .clk     (clk),
      .resetn  (resetn),
      .we      (cfg_we && (cfg_addr[CHW:1] == CHW'(g))),
      .word    (cfg_addr[0]),
      .wdata   (cfg_wdata),
      .grant   (gnt[g]),
      .pending (pend[g]),
      .overrun (overrun[g]),
      .anode   (an[g]),
      .cathode (ca[g]),
      .level   (lvl[g]),
      .pd      (pdv[g])
    );
  end

  seq_state_e      state, state_n;
  logic [PDW-1:0]  tick, tick_n, pd_q, nxt_pd;
  logic [EW-1:0]   an_q, ca_q, nxt_an, nxt_ca;
  logic [AW-1:0]   lvl_q, nxt_lvl, dac_n;
  logic [NELE-1:0] up_n, dn_n;
  logic            act_n, found, latch;
  logic [CHW-1:0]  sel;

  always_comb begin
    sel   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (pend[i] && !found) begin
        sel   = CHW'(i);
        found = 1'b1;
      end
    end
  end

  // Grants are accepted from DEAD as well as IDLE so queued channels follow
  // the dead tick with no idle gap.
  always_comb begin
    state_n = state;
    tick_n  = tick;
    latch   = 1'b0;
    case (state)
      S_IDLE, S_DEAD: begin
        if (found) begin
          state_n = S_PH1;
          tick_n  = PDW'(1);
          latch   = 1'b1;
        end else begin
          state_n = S_IDLE;
        end
      end
      S_PH1: begin
        if (tick == pd_q) state_n = S_GAP;
        else              tick_n  = tick + PDW'(1);
      end
      S_GAP: begin
        state_n = S_PH2;
        tick_n  = PDW'(1);
      end
      S_PH2: begin
        if (tick == pd_q) state_n = S_DEAD;
        else              tick_n  = tick + PDW'(1);
      end
      default: state_n = S_IDLE;
    endcase

    gnt = '0;
    if (latch) gnt[sel] = 1'b1;

    nxt_an  = latch ? an[sel]  : an_q;
    nxt_ca  = latch ? ca[sel]  : ca_q;
    nxt_lvl = latch ? lvl[sel] : lvl_q;
    nxt_pd  = latch ? pdv[sel] : pd_q;

    up_n  = '0;
    dn_n  = '0;
    dac_n = '0;
    act_n = 1'b0;
    case (state_n)
      S_PH1: begin
        for (int unsigned e = 0; e < NELE; e++) begin
          up_n[e] = (e == 32'(nxt_an));
          dn_n[e] = (e == 32'(nxt_ca));
        end
        dac_n = nxt_lvl;
        act_n = 1'b1;
      end
      S_GAP: begin
        dac_n = nxt_lvl;
        act_n = 1'b1;
      end
      S_PH2: begin
        for (int unsigned e = 0; e < NELE; e++) begin
          up_n[e] = (e == 32'(nxt_ca));
          dn_n[e] = (e == 32'(nxt_an));
        end
        dac_n = nxt_lvl;
        act_n = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state         <= S_IDLE;
      tick          <= '0;
      an_q          <= '0;
      ca_q          <= '0;
      lvl_q         <= '0;
      pd_q          <= '0;
      active_ch     <= '0;
      up_switches   <= '0;
      down_switches <= '0;
      DAC           <= '0;
      pulse_active  <= 1'b0;
    end else begin
      state         <= state_n;
      tick          <= tick_n;
      an_q          <= nxt_an;
      ca_q          <= nxt_ca;
      lvl_q         <= nxt_lvl;
      pd_q          <= nxt_pd;
      if (latch) active_ch <= sel;
      up_switches   <= up_n;
      down_switches <= dn_n;
      DAC           <= dac_n;
      pulse_active  <= act_n;
    end
  end

endmodule

// File: tb/tb_aska_mnpg.sv
// Bench for aska_mnpg: directed scenarios plus random config traffic, checked
// every cycle against a time-stamp based reference model.
module tb_aska_mnpg;

  localparam int NCH  = 4;
  localparam int NELE = 32;
  localparam int AW   = 6;
  localparam int CHW  = 2;

  logic            clk = 1'b0;
  logic            resetn = 1'b0;
  logic            cfg_we = 1'b0;
  logic [CHW:0]    cfg_addr = '0;
  logic [31:0]     cfg_wdata = '0;
  logic [NELE-1:0] up_switches, down_switches;
  logic [AW-1:0]   DAC;
  logic            pulse_active;
  logic [CHW-1:0]  active_ch;
  logic [NCH-1:0]  overrun;

  aska_mnpg #(.NCH(NCH), .NELE(NELE), .AW(AW)) dut (
    .clk           (clk),
    .resetn        (resetn),
    .cfg_we        (cfg_we),
    .cfg_addr      (cfg_addr),
    .cfg_wdata     (cfg_wdata),
    .up_switches   (up_switches),
    .down_switches (down_switches),
    .DAC           (DAC),
    .pulse_active  (pulse_active),
    .active_ch     (active_ch),
    .overrun       (overrun)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Reference model: config words, request flags, absolute time of the next
  // period boundary, and the current pulse described by its start time.
  logic [31:0] m_c0 [NCH];
  logic [31:0] m_c1 [NCH];
  bit          m_pend [NCH];
  bit          m_ovr  [NCH];
  bit          m_off  [NCH];
  int          m_idx  [NCH];
  int          m_offc [NCH];
  int          m_nb   [NCH];
  bit          m_busy;
  int          m_t0, m_pd, m_an, m_ca, m_lvl, m_act;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mk0(input int per, input int amp, input int on);
    return 32'(per) | (32'(amp) << 12) | (32'(on) << 24);
  endfunction

  function automatic logic [31:0] mk1(input int off, input int pd, input int en,
                                      input int an, input int ca, input int rmp);
    return 32'(off) | (32'(pd) << 10) | (32'(en) << 13) | (32'(an) << 14) |
           (32'(ca) << 19) | (32'(rmp) << 24);
  endfunction

  function automatic bit ref_valid(input int ch);
    int an, ca;
    an = int'(m_c1[ch][18:14]);
    ca = int'(m_c1[ch][23:19]);
    return m_c1[ch][13] && (m_c0[ch][11:0] != 0) && (an != ca) && (an < NELE) && (ca < NELE);
  endfunction

  function automatic int ref_level(input int ch);
    int amp, rs, v;
    amp = int'(m_c0[ch][17:12]);
    rs  = int'(m_c1[ch][29:24]);
    if (rs == 0) return amp;
    v = (m_idx[ch] + 1) * rs;
    return (v < amp) ? v : amp;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_c0[i] = '0; m_c1[i] = '0; m_pend[i] = 0; m_ovr[i] = 0;
      m_off[i] = 0; m_idx[i] = 0; m_offc[i] = 0; m_nb[i] = 0;
    end
    m_busy = 0; m_t0 = 0; m_pd = 1; m_an = 0; m_ca = 0; m_lvl = 0; m_act = 0;
  endtask

  task automatic model_edge(input bit we, input int wch, input bit wword, input logic [31:0] d);
    bit vold [NCH];
    bit vnew, bnd, onb, gi;
    int g, per, on, off;
    if (m_busy && cyc >= m_t0 + 2 * m_pd + 2) m_busy = 0;
    g = -1;
    if (!m_busy)
      for (int i = 0; i < NCH; i++) if (m_pend[i] && g < 0) g = i;
    if (g >= 0) begin
      m_an  = int'(m_c1[g][18:14]);
      m_ca  = int'(m_c1[g][23:19]);
      m_lvl = ref_level(g);
      m_pd  = (m_c1[g][12:10] == 0) ? 1 : int'(m_c1[g][12:10]);
      m_t0  = cyc;
      m_busy = 1;
      m_act = g;
    end
    for (int i = 0; i < NCH; i++) vold[i] = ref_valid(i);
    if (we && wch < NCH) begin
      if (wword) m_c1[wch] = d;
      else       m_c0[wch] = d;
    end
    for (int i = 0; i < NCH; i++) begin
      vnew = ref_valid(i);
      gi   = (g == i);
      per  = int'(m_c0[i][11:0]);
      on   = int'(m_c0[i][31:24]);
      off  = int'(m_c1[i][9:0]);
      if (!vnew) begin
        m_pend[i] = 0; m_idx[i] = 0; m_off[i] = 0; m_offc[i] = 0;
      end else if (!vold[i]) begin
        m_nb[i] = cyc + per; m_pend[i] = 1; m_idx[i] = 0; m_off[i] = 0; m_offc[i] = 0;
      end else begin
        bnd = (cyc == m_nb[i]);
        if (bnd) m_nb[i] = cyc + per;
        onb = bnd && !m_off[i];
        if (onb && m_pend[i] && !gi) m_ovr[i] = 1;
        m_pend[i] = (m_pend[i] && !gi) || onb;
        if (gi) begin
          if (on != 0 && off != 0 && m_idx[i] + 1 >= on) begin
            m_off[i] = 1; m_idx[i] = 0; m_offc[i] = 0;
          end else if (m_idx[i] < 255) begin
            m_idx[i]++;
          end
        end else if (bnd && m_off[i]) begin
          if (m_offc[i] + 1 >= off) begin m_off[i] = 0; m_offc[i] = 0; end
          else m_offc[i]++;
        end
      end
    end
  endtask

  task automatic check_outputs();
    logic [31:0] eu, ed;
    int edac, off;
    bit ep;
    logic [NCH-1:0] eo;
    eu = '0; ed = '0; edac = 0; ep = 0;
    if (m_busy && cyc <= m_t0 + 2 * m_pd + 1) begin
      off = cyc - m_t0;
      if (off < m_pd) begin
        eu = 32'd1 << m_an; ed = 32'd1 << m_ca; edac = m_lvl; ep = 1;
      end else if (off == m_pd) begin
        edac = m_lvl; ep = 1;
      end else if (off <= 2 * m_pd) begin
        eu = 32'd1 << m_ca; ed = 32'd1 << m_an; edac = m_lvl; ep = 1;
      end
    end
    for (int i = 0; i < NCH; i++) eo[i] = m_ovr[i];
    chk("up_switches", 64'(up_switches), 64'(eu));
    chk("down_switches", 64'(down_switches), 64'(ed));
    chk("DAC", 64'(DAC), 64'(edac));
    chk("pulse_active", 64'(pulse_active), 64'(ep));
    chk("active_ch", 64'(active_ch), 64'(m_act));
    chk("overrun", 64'(overrun), 64'(eo));
  endtask

  task automatic step(input bit we, input int ch, input bit word, input logic [31:0] d);
    cfg_we    = we;
    cfg_addr  = (CHW + 1)'(ch * 2 + int'(word));
    cfg_wdata = d;
    @(posedge clk);
    cyc++;
    model_edge(we, ch, word, d);
    #1;
    check_outputs();
    cfg_we = 1'b0;
  endtask

  task automatic idle(input int k);
    repeat (k) step(1'b0, 0, 1'b0, '0);
  endtask

  task automatic wr(input int ch, input bit word, input logic [31:0] d);
    step(1'b1, ch, word, d);
  endtask

  task automatic do_reset();
    #1 resetn = 1'b0;
    cfg_we = 1'b0;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #3 resetn = 1'b1;
  endtask

  int st_dac[$];
  int st_cyc[$];
  int exp_dac[7] = '{5, 10, 15, 20, 20, 20, 5};
  int act_cnt;
  bit prev;

  initial begin
    model_reset();
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_up", 64'(up_switches), 64'd0);
    chk("rst_down", 64'(down_switches), 64'd0);
    chk("rst_dac", 64'(DAC), 64'd0);
    chk("rst_active", 64'(pulse_active), 64'd0);
    chk("rst_ovr", 64'(overrun), 64'd0);
    #2 resetn = 1'b1;

    // Basic biphasic pulse, period 400
    wr(0, 1'b0, mk0(400, 20, 0));
    wr(0, 1'b1, mk1(0, 2, 1, 1, 2, 0));
    chk("t1_quiet_after_write", 64'(pulse_active), 64'd0);
    idle(1);
    chk("t1_ph1_up", 64'(up_switches), 64'h2);
    chk("t1_ph1_down", 64'(down_switches), 64'h4);
    chk("t1_ph1_dac", 64'(DAC), 64'd20);
    idle(2);
    chk("t1_gap_up", 64'(up_switches), 64'h0);
    idle(1);
    chk("t1_ph2_up", 64'(up_switches), 64'h4);
    chk("t1_ph2_down", 64'(down_switches), 64'h2);
    idle(900);

    // Ramp with ON/OFF windows
    do_reset();
    wr(0, 1'b0, mk0(20, 20, 6));
    wr(0, 1'b1, mk1(3, 1, 1, 1, 2, 5));
    prev = 1'b1;
    for (int k = 0; k < 230; k++) begin
      if (k > 0) idle(1);
      if (pulse_active && !prev) begin
        st_dac.push_back(int'(DAC));
        st_cyc.push_back(cyc);
      end
      prev = pulse_active;
    end
    chk("t2_pulse_count", 64'(st_dac.size() >= 7), 64'd1);
    if (st_dac.size() >= 7) begin
      for (int i = 0; i < 7; i++) chk("t2_ramp_dac", 64'(st_dac[i]), 64'(exp_dac[i]));
      chk("t2_off_gap", 64'(st_cyc[6] - st_cyc[5]), 64'd80);
    end

    // Two channels contending
    do_reset();
    wr(0, 1'b0, mk0(100, 10, 0));
    wr(1, 1'b0, mk0(100, 30, 0));
    wr(0, 1'b1, mk1(0, 2, 1, 1, 2, 0));
    wr(1, 1'b1, mk1(0, 2, 1, 3, 4, 0));
    chk("t3_first_owner", 64'(active_ch), 64'd0);
    idle(5);
    chk("t3_dead", 64'(pulse_active), 64'd0);
    idle(1);
    chk("t3_second_owner", 64'(active_ch), 64'd1);
    chk("t3_second_up", 64'(up_switches), 64'h8);
    chk("t3_second_dac", 64'(DAC), 64'd30);
    idle(300);
    chk("t3_no_overrun", 64'(overrun), 64'd0);

    // Period shorter than the pulse
    do_reset();
    wr(0, 1'b0, mk0(4, 15, 0));
    wr(0, 1'b1, mk1(0, 7, 1, 1, 2, 0));
    idle(100);
    chk("t4_overrun", 64'(overrun[0]), 64'd1);
    wr(0, 1'b0, mk0(8, 15, 0));
    idle(50);
    chk("t4_overrun_sticky", 64'(overrun[0]), 64'd1);

    // Disable mid-pulse
    do_reset();
    wr(0, 1'b0, mk0(50, 25, 0));
    wr(0, 1'b1, mk1(0, 3, 1, 0, 5, 0));
    idle(2);
    wr(0, 1'b1, mk1(0, 3, 0, 0, 5, 0));
    idle(1);
    chk("t5_gap_dac", 64'(DAC), 64'd25);
    idle(1);
    chk("t5_ph2_up", 64'(up_switches), 64'h20);
    chk("t5_ph2_down", 64'(down_switches), 64'h1);
    idle(3);
    act_cnt = 0;
    for (int k = 0; k < 200; k++) begin
      idle(1);
      if (pulse_active) act_cnt++;
    end
    chk("t5_no_more_pulses", 64'(act_cnt), 64'd0);

    // Invalid electrodes, then asynchronous reset mid-pulse
    do_reset();
    wr(2, 1'b0, mk0(10, 40, 0));
    wr(2, 1'b1, mk1(0, 3, 1, 3, 3, 0));
    act_cnt = 0;
    for (int k = 0; k < 60; k++) begin
      idle(1);
      if (pulse_active || up_switches != 0 || down_switches != 0) act_cnt++;
    end
    chk("t6_invalid_silent", 64'(act_cnt), 64'd0);
    wr(2, 1'b1, mk1(0, 3, 1, 3, 4, 0));
    idle(2);
    chk("t6_pulse_running", 64'(pulse_active), 64'd1);
    #1 resetn = 1'b0;
    #1;
    chk("t6_async_up", 64'(up_switches), 64'd0);
    chk("t6_async_down", 64'(down_switches), 64'd0);
    chk("t6_async_dac", 64'(DAC), 64'd0);
    chk("t6_async_active", 64'(pulse_active), 64'd0);
    model_reset();
    @(posedge clk);
    #3 resetn = 1'b1;
    idle(30);

    // Random configuration traffic
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 29) == 0) begin
        if ($urandom_range(0, 1) == 0)
          wr(int'($urandom_range(0, NCH - 1)), 1'b0,
             mk0(int'($urandom_range(1, 48)), int'($urandom_range(0, 63)),
                 int'($urandom_range(0, 5))));
        else
          wr(int'($urandom_range(0, NCH - 1)), 1'b1,
             mk1(int'($urandom_range(0, 3)), int'($urandom_range(0, 4)),
                 int'($urandom_range(0, 3) != 0), int'($urandom_range(0, 5)),
                 int'($urandom_range(0, 5)), int'($urandom_range(0, 20))));
      end else begin
        idle(1);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
